// File: rtl/itrx_amba4_axilite_regif.sv
// AXI4-Lite slave to simple req/ack register bus bridge, one outstanding access.
// Latency: handshake to reg_req 2 cycles; reg_ack to bvalid/rvalid 1 cycle (3 cycles minimum overall).
// Backpressure: AW/W/AR are only accepted in IDLE with the holder empty; B/R are held until bready/rready.
//
// Ports:
//   aclk, areset             clock, synchronous active-high reset
//   aw*/w*/b*                AXI4-Lite write address, data and response channels
//   ar*/r*                   AXI4-Lite read address and data channels
//   reg_req/wr/addr/wdata/wstrb  register access request, held until reg_ack or timeout
//   reg_ack/err/rdata        register access completion, error flag and read data
module itrx_amba4_axilite_regif #(
   parameter int XADDRW  = 32,
   parameter int XDATAW  = 64,
   parameter int XIDW    = 4,
   parameter int TMO_CYC = 255,
   localparam int XSTRBW = XDATAW / 8
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [XIDW-1:0]   awid,
   input  logic [XADDRW-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [XDATAW-1:0] wdata,
   input  logic [XSTRBW-1:0] wstrb,
   input  logic              wvalid,
   output logic              wready,
   output logic [XIDW-1:0]   bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [XIDW-1:0]   arid,
   input  logic [XADDRW-1:0] araddr,
   input  logic              arvalid,
   output logic              arready,
   output logic [XIDW-1:0]   rid,
   output logic [XDATAW-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready,
   output logic              reg_req,
   output logic              reg_wr,
   output logic [XADDRW-1:0] reg_addr,
   output logic [XDATAW-1:0] reg_wdata,
   output logic [XSTRBW-1:0] reg_wstrb,
   input  logic              reg_ack,
   input  logic              reg_err,
   input  logic [XDATAW-1:0] reg_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_WRSP = 2'd2;
   localparam logic [1:0] S_RRSP = 2'd3;

   // Counter saturates the access at TMO_CYC cycles without reg_ack.
   localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

   logic [1:0]        state;
   logic              aw_full, w_full, ar_full;
   logic [XIDW-1:0]   aw_id, ar_id;
   logic [XADDRW-1:0] aw_addr, ar_addr;
   logic [XDATAW-1:0] w_data;
   logic [XSTRBW-1:0] w_strb;
   logic [15:0]       tmo_cnt;
   logic              rd_first;
   logic [1:0]        resp_q;
   logic [XDATAW-1:0] rdata_q;

   logic wr_pend, rd_pend, grant_wr, tmo_hit;
   logic aw_hs, w_hs, ar_hs;

   assign awready = !areset && (state == S_IDLE) && !aw_full;
   assign wready  = !areset && (state == S_IDLE) && !w_full;
   assign arready = !areset && (state == S_IDLE) && !ar_full;

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid  && wready;
   assign ar_hs = arvalid && arready;

   assign wr_pend  = aw_full && w_full;
   assign rd_pend  = ar_full;
   // The toggle only arbitrates collisions; a lone request is granted directly.
   assign grant_wr = wr_pend && (!rd_pend || !rd_first);
   assign tmo_hit  = (tmo_cnt == TMO_LAST);

   assign bvalid = (state == S_WRSP);
   assign rvalid = (state == S_RRSP);
   assign bid    = aw_id;
   assign rid    = ar_id;
   assign bresp  = resp_q;
   assign rresp  = resp_q;
   assign rdata  = rdata_q;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state     <= S_IDLE;
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         ar_full   <= 1'b0;
         aw_id     <= '0;
         aw_addr   <= '0;
         w_data    <= '0;
         w_strb    <= '0;
         ar_id     <= '0;
         ar_addr   <= '0;
         tmo_cnt   <= '0;
         rd_first  <= 1'b0;
         resp_q    <= 2'b00;
         rdata_q   <= '0;
         reg_req   <= 1'b0;
         reg_wr    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_wstrb <= '0;
      end else begin
         if (aw_hs) begin
            aw_full <= 1'b1;
            aw_id   <= awid;
            aw_addr <= awaddr;
         end
         if (w_hs) begin
            w_full <= 1'b1;
            w_data <= wdata;
            w_strb <= wstrb;
         end
         if (ar_hs) begin
            ar_full <= 1'b1;
            ar_id   <= arid;
            ar_addr <= araddr;
         end

         case (state)
            S_IDLE: begin
               if (wr_pend || rd_pend) begin
                  state   <= S_ACC;
                  reg_req <= 1'b1;
                  tmo_cnt <= '0;
                  if (grant_wr) begin
                     reg_wr    <= 1'b1;
                     reg_addr  <= aw_addr;
                     reg_wdata <= w_data;
                     reg_wstrb <= w_strb;
                  end else begin
                     reg_wr    <= 1'b0;
                     reg_addr  <= ar_addr;
                     reg_wdata <= '0;
                     reg_wstrb <= '0;
                  end
                  if (wr_pend && rd_pend) rd_first <= !rd_first;
               end
            end
            S_ACC: begin
               // reg_ack wins over a timeout landing in the same cycle.
               if (reg_ack || tmo_hit) begin
                  reg_req <= 1'b0;
                  state   <= reg_wr ? S_WRSP : S_RRSP;
                  if (reg_ack) begin
                     resp_q  <= reg_err ? 2'b10 : 2'b00;
                     rdata_q <= reg_wr ? '0 : reg_rdata;
                  end else begin
                     resp_q  <= 2'b11;
                     rdata_q <= '0;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            S_WRSP: begin
               if (bready) begin
                  state   <= S_IDLE;
                  aw_full <= 1'b0;
                  w_full  <= 1'b0;
               end
            end
            default: begin
               if (rready) begin
                  state   <= S_IDLE;
                  ar_full <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
